uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 18 +
 rtl/uart_tx_arbiter_rr_select.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Holds the arbiter state enum, default sizing and an index-width helper.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  localparam int N_CLIENTS_DEFAULT = 3;
  localparam int TIMEOUT_DEFAULT   = 1024;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational round-robin selector: picks the first requester after i_last,
// wrapping from N-1 back to 0.
module rr_select #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int w_dist;
  int w_best;

  // Distance from the last grantee; the smallest distance among requesters wins.
  always_comb begin
    w_dist = 0;
    w_best = N;
    o_idx  = '0;
    for (int j = 0; j < N; j++) begin
      w_dist = j - int'(i_last) - 1;
      if (w_dist < 0) w_dist = w_dist + N;
      if (i_req[j] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_idx  = IW'(j);
      end
    end
    o_any = (w_best < N);
    o_gnt = '0;
    for (int j = 0; j < N; j++) begin
      o_gnt[j] = o_any && (o_idx == IW'(j));
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_CLIENTS message printers with
// round-robin grants, a one-cycle gap between messages and an idle timeout.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_CLIENTS = N_CLIENTS_DEFAULT,
  parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CLIENTS-1:0]   cli_req,
  input  logic [N_CLIENTS-1:0]   cli_wr,
  input  logic [8*N_CLIENTS-1:0] cli_d,
  output logic [N_CLIENTS-1:0]   cli_gnt,
  output logic [N_CLIENTS-1:0]   cli_ready,
  output logic                   uart_wr,
  output logic [7:0]             uart_d,
  input  logic                   uart_ready,
  output logic                   timeout_err
);

  localparam int IW = idx_width(N_CLIENTS);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [IW-1:0] LAST_RST = IW'(N_CLIENTS - 1);

  arb_state_t r_state, w_state_nx;
  logic [N_CLIENTS-1:0] r_gnt, w_gnt_nx;
  logic [N_CLIENTS-1:0] r_mask, w_mask_nx;
  logic [IW-1:0]        r_idx, w_idx_nx;
  logic [IW-1:0]        r_last, w_last_nx;
  logic [CW-1:0]        r_cnt, w_cnt_nx;
  logic                 r_uart_wr, w_uart_wr_nx;
  logic [7:0]           r_uart_d, w_uart_d_nx;
  logic                 r_terr, w_terr_nx;

  logic [N_CLIENTS-1:0] w_sel_gnt;
  logic [IW-1:0]        w_sel_idx;
  logic                 w_sel_any;
  logic                 w_g_req;
  logic                 w_g_wr;
  logic [7:0]           w_g_d;
  logic                 w_accept;

  rr_select #(
    .N  (N_CLIENTS),
    .IW (IW)
  ) u_rr_select (
    .i_req  (cli_req & ~r_mask),
    .i_last (r_last),
    .o_gnt  (w_sel_gnt),
    .o_idx  (w_sel_idx),
    .o_any  (w_sel_any)
  );

  always_comb begin
    w_g_req = 1'b0;
    w_g_wr  = 1'b0;
    w_g_d   = 8'h00;
    for (int j = 0; j < N_CLIENTS; j++) begin
      if (r_idx == IW'(j)) begin
        w_g_req = cli_req[j];
        w_g_wr  = cli_wr[j];
        w_g_d   = cli_d[j*8 +: 8];
      end
    end
  end

  assign cli_ready = ((r_state == ST_GRANT) && uart_ready) ? r_gnt : '0;
  assign w_accept  = (r_state == ST_GRANT) && uart_ready && w_g_wr;

  always_comb begin
    w_state_nx   = r_state;
    w_gnt_nx     = r_gnt;
    w_idx_nx     = r_idx;
    w_last_nx    = r_last;
    w_cnt_nx     = r_cnt;
    w_mask_nx    = r_mask & cli_req;
    w_terr_nx    = 1'b0;
    w_uart_wr_nx = w_accept;
    w_uart_d_nx  = w_accept ? w_g_d : r_uart_d;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_any) begin
          w_state_nx = ST_GRANT;
          w_gnt_nx   = w_sel_gnt;
          w_idx_nx   = w_sel_idx;
          w_last_nx  = w_sel_idx;
          w_cnt_nx   = '0;
        end
      end
      ST_GRANT: begin
        // A falling request takes precedence, so a same-cycle timeout is a plain release.
        if (!w_g_req) begin
          w_state_nx = ST_RELEASE;
          w_gnt_nx   = '0;
        end else if (w_accept) begin
          w_cnt_nx = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nx = ST_RELEASE;
          w_gnt_nx   = '0;
          w_terr_nx  = 1'b1;
          w_mask_nx  = (r_mask & cli_req) | r_gnt;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = '0;
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_gnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_idx     <= '0;
      r_last    <= LAST_RST;
      r_cnt     <= '0;
      r_mask    <= '0;
      r_uart_wr <= 1'b0;
      r_uart_d  <= 8'h00;
      r_terr    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_gnt     <= w_gnt_nx;
      r_idx     <= w_idx_nx;
      r_last    <= w_last_nx;
      r_cnt     <= w_cnt_nx;
      r_mask    <= w_mask_nx;
      r_uart_wr <= w_uart_wr_nx;
      r_uart_d  <= w_uart_d_nx;
      r_terr    <= w_terr_nx;
    end
  end

  assign cli_gnt     = r_gnt;
  assign uart_wr     = r_uart_wr;
  assign uart_d      = r_uart_d;
  assign timeout_err = r_terr;

endmodule
